vga_plot_scheduler: RTL and testbench

- Sits between the control path's VGA plot decode and the VGA framebuffer adapter.
- Queues single-pixel plot requests in a small FIFO and sequences them to the adapter through a valid/ready handshake.
- Also runs a full-screen clear sweep on request.
- The processor can therefore issue plots back-to-back without waiting on the adapter. Overflow and busy status are reported back to it.

---
 rtl/vga_pkg.sv | 19 +
 rtl/plot_fifo.sv | 60 ++++++
 rtl/vga_plot_scheduler.sv | 154 +++++++++++++++
 tb/tb_vga_plot_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA plot scheduler: FSM encodings, default
// screen geometry and the packed plot-entry width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } sched_state_t;

  localparam int X_MAX_DEF   = 160;
  localparam int Y_MAX_DEF   = 120;
  localparam int COORD_Y_LSB = 8;

  function automatic int entry_w(input int xb, input int yb, input int cb);
    return xb + yb + cb;
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Small synchronous FIFO holding packed plot entries; head is the oldest
// entry and is valid whenever empty is low.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/vga_plot_scheduler.sv
// Queues pixel plots and full-screen clears, and feeds them one pixel per
// transfer to the framebuffer adapter over a valid/ready output stage.
module vga_plot_scheduler
  import vga_pkg::*;
#(
  parameter int X_BITS      = 8,
  parameter int Y_BITS      = 7,
  parameter int COLOR_BITS  = 3,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int DEPTH       = 4,
  parameter int CLEAR_COLOR = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  plot_req,
  input  logic [15:0]           plot_coord,
  input  logic [15:0]           plot_color,
  input  logic                  clear_req,
  output logic [X_BITS-1:0]     vga_x,
  output logic [Y_BITS-1:0]     vga_y,
  output logic [COLOR_BITS-1:0] vga_color,
  output logic                  vga_write,
  input  logic                  vga_ready,
  output logic                  fifo_full,
  output logic                  busy,
  output logic                  overflow
);

  localparam int ENTRY_W = entry_w(X_BITS, Y_BITS, COLOR_BITS);

  sched_state_t          state_q, state_d;
  logic [X_BITS-1:0]     cx_q, cx_d, x_q, x_d;
  logic [Y_BITS-1:0]     cy_q, cy_d, y_q, y_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic                  write_q, write_d;
  logic                  clear_pending_q, clear_pending_d;
  logic                  overflow_q, overflow_d;
  logic                  start_clear, can_load;

  logic [ENTRY_W-1:0]    fifo_din, fifo_head;
  logic                  fifo_push, fifo_pop, fifo_empty;
  logic                  unused_in;

  assign fifo_din  = {plot_coord[X_BITS-1:0],
                      plot_coord[COORD_Y_LSB+Y_BITS-1:COORD_Y_LSB],
                      plot_color[COLOR_BITS-1:0]};
  assign fifo_push = plot_req & ~fifo_full;
  assign unused_in = ^{plot_coord, plot_color};

  plot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // The output stage is free when empty or when its pixel transfers this edge.
  assign can_load = ~write_q | vga_ready;

  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    x_d         = x_q;
    y_d         = y_q;
    color_d     = color_q;
    write_d     = write_q;
    fifo_pop    = 1'b0;
    start_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (!fifo_empty) begin
          state_d = ST_DRAIN;
          if (can_load) begin
            fifo_pop = 1'b1;
            write_d  = 1'b1;
            x_d      = fifo_head[ENTRY_W-1 -: X_BITS];
            y_d      = fifo_head[COLOR_BITS +: Y_BITS];
            color_d  = fifo_head[COLOR_BITS-1:0];
          end
        end else begin
          state_d = ST_IDLE;
          if (can_load) write_d = 1'b0;
          // Queued plots always win over a pending clear.
          if (state_q == ST_IDLE && clear_pending_q) begin
            state_d     = ST_CLEAR;
            cx_d        = '0;
            cy_d        = '0;
            start_clear = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (can_load) begin
          write_d = 1'b1;
          x_d     = cx_q;
          y_d     = cy_q;
          color_d = COLOR_BITS'(CLEAR_COLOR);
          if (cx_q == X_BITS'(X_MAX - 1)) begin
            cx_d = '0;
            if (cy_q == Y_BITS'(Y_MAX - 1)) state_d = ST_IDLE;
            else                           cy_d    = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    clear_pending_d = (clear_pending_q & ~start_clear) |
                      (clear_req & (state_q != ST_CLEAR));
    overflow_d      = overflow_q | (plot_req & fifo_full);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cx_q            <= '0;
      cy_q            <= '0;
      x_q             <= '0;
      y_q             <= '0;
      color_q         <= '0;
      write_q         <= 1'b0;
      clear_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      x_q             <= x_d;
      y_q             <= y_d;
      color_q         <= color_d;
      write_q         <= write_d;
      clear_pending_q <= clear_pending_d;
      overflow_q      <= overflow_d;
    end
  end

  assign vga_x     = x_q;
  assign vga_y     = y_q;
  assign vga_color = color_q;
  assign vga_write = write_q;
  assign overflow  = overflow_q;
  assign busy      = ~fifo_empty | write_q | clear_pending_q | (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler on a 4x2 screen with a 4-entry FIFO.
module tb_vga_plot_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        plot_req = 1'b0;
  logic [15:0] plot_coord = '0;
  logic [15:0] plot_color = '0;
  logic        clear_req = 1'b0;
  logic        vga_ready = 1'b0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        vga_write, fifo_full, busy, overflow;

  vga_plot_scheduler #(
    .X_BITS(8), .Y_BITS(7), .COLOR_BITS(3),
    .X_MAX(4), .Y_MAX(2), .DEPTH(4), .CLEAR_COLOR(0)
  ) dut (
    .clock(clock), .reset(reset), .plot_req(plot_req), .plot_coord(plot_coord),
    .plot_color(plot_color), .clear_req(clear_req), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_write(vga_write), .vga_ready(vga_ready),
    .fifo_full(fifo_full), .busy(busy), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] coord;
    logic [15:0] color;
    logic [17:0] exp;
  } vec_t;

  vec_t        vecs [10];
  logic [17:0] log_q [$];
  logic [17:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic        stall_prev = 1'b0;
  logic [18:0] prev_out = '0;

  function automatic logic [17:0] mk(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    return {x, y, c};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transfers are logged half a cycle before the edge that completes them.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({vga_write, vga_x, vga_y, vga_color} != prev_out) begin
          errors++;
          $display("FAIL stall_stable: got %h expected %h", {vga_write, vga_x, vga_y, vga_color}, prev_out);
        end
      end
      if (vga_write && vga_ready) log_q.push_back({vga_x, vga_y, vga_color});
      stall_prev = vga_write && !vga_ready;
      prev_out   = {vga_write, vga_x, vga_y, vga_color};
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] c, input logic [15:0] col);
    plot_req   = 1'b1;
    plot_coord = c;
    plot_color = col;
    tick();
    plot_req   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_px%0d", name, i), int'(log_q[i]), int'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    log_q.delete();
  endtask

  initial begin
    vecs[0] = '{16'h0A05, 16'h0003, mk(8'h05, 7'h0A, 3'd3)};
    vecs[1] = '{16'h0000, 16'h0007, mk(8'h00, 7'h00, 3'd7)};
    vecs[2] = '{16'hFF05, 16'h00FE, mk(8'h05, 7'h7F, 3'd6)};
    vecs[3] = '{16'h7FFF, 16'h0001, mk(8'hFF, 7'h7F, 3'd1)};
    vecs[4] = '{16'h8012, 16'h0002, mk(8'h12, 7'h00, 3'd2)};
    vecs[5] = '{16'h1234, 16'h0005, mk(8'h34, 7'h12, 3'd5)};
    vecs[6] = '{16'h3C9F, 16'hFFF4, mk(8'h9F, 7'h3C, 3'd4)};
    vecs[7] = '{16'h779A, 16'h0006, mk(8'h9A, 7'h77, 3'd6)};
    vecs[8] = '{16'h0150, 16'h0009, mk(8'h50, 7'h01, 3'd1)};
    vecs[9] = '{16'h6E01, 16'h0000, mk(8'h01, 7'h6E, 3'd0)};

    // Reset values
    tick();
    tick();
    chk("rst_write", int'(vga_write), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_color", int'(vga_color), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_full", int'(fifo_full), 0);
    reset = 1'b0;
    tick();

    // Single plot: visible one edge after the push edge, gone after the transfer
    vga_ready = 1'b1;
    push(16'h0A05, 16'h0003);
    chk("single_lat0", int'(vga_write), 0);
    tick();
    chk("single_write", int'(vga_write), 1);
    chk("single_x", int'(vga_x), 5);
    chk("single_y", int'(vga_y), 10);
    chk("single_color", int'(vga_color), 3);
    tick();
    chk("single_done", int'(vga_write), 0);
    chk("single_busy", int'(busy), 0);
    exp_q.push_back(mk(8'h05, 7'h0A, 3'd3));
    check_log("single");

    // Backpressure: the first plot occupies the output stage, so five
    // pushes fill the FIFO and the sixth overflows.
    vga_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(vecs[i].coord, vecs[i].color);
    chk("bp_full", int'(fifo_full), 1);
    chk("bp_no_ovf", int'(overflow), 0);
    push(vecs[5].coord, vecs[5].color);
    chk("bp_ovf", int'(overflow), 1);
    chk("bp_hold_x", int'(vga_x), int'(vecs[0].exp[17:10]));
    tick();
    vga_ready = 1'b1;
    wait_idle("bp", 30);
    chk("bp_ovf_sticky", int'(overflow), 1);
    chk("bp_full_clr", int'(fifo_full), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(vecs[i].exp);
    check_log("bp");
    do_reset();
    chk("bp_ovf_reset", int'(overflow), 0);

    // Clear sweep over the 4x2 screen
    vga_ready = 1'b1;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy", int'(busy), 1);
    wait_idle("clr", 40);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) exp_q.push_back(mk(8'(x), 7'(y), 3'd0));
    check_log("clr");

    // Ordering: queued plots before the clear, mid-clear plot after it
    push(vecs[6].coord, vecs[6].color);
    clear_req = 1'b1;
    push(vecs[7].coord, vecs[7].color);
    clear_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    push(vecs[8].coord, vecs[8].color);
    wait_idle("ord", 60);
    exp_q.push_back(vecs[6].exp);
    exp_q.push_back(vecs[7].exp);
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) exp_q.push_back(mk(8'(x), 7'(y), 3'd0));
    exp_q.push_back(vecs[8].exp);
    check_log("ord");

    // Back-to-back pushes with simultaneous pops
    for (int i = 0; i < 10; i++) begin
      plot_req   = 1'b1;
      plot_coord = vecs[i].coord;
      plot_color = vecs[i].color;
      tick();
      chk($sformatf("b2b_full%0d", i), int'(fifo_full), 0);
    end
    plot_req = 1'b0;
    wait_idle("b2b", 30);
    chk("b2b_ovf", int'(overflow), 0);
    for (int i = 0; i < 10; i++) exp_q.push_back(vecs[i].exp);
    check_log("b2b");

    // Reset in the middle of a clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    begin
      int n = 0;
      while (!vga_write && n < 20) begin
        tick();
        n++;
      end
    end
    tick();
    chk("mid_clr_write", int'(vga_write), 1);
    reset = 1'b1;
    #1;
    chk("async_rst_write", int'(vga_write), 0);
    tick();
    reset = 1'b0;
    log_q.delete();
    for (int i = 0; i < 20; i++) tick();
    chk("post_rst_xfers", log_q.size(), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_write", int'(vga_write), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
